// File: rtl/llc_rst_flush_seq.sv
// llc_rst_flush_seq: walks LLC sets for reset tag clearing and for flush
// write-back/invalidate, driving the set-pointer register strobes.
module llc_rst_flush_seq #(
    parameter int LLC_SETS = 512,
    parameter int LLC_WAYS = 16,
    localparam int SW = $clog2(LLC_SETS),
    localparam int WW = $clog2(LLC_WAYS)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_rst_stall,
    input  logic                i_flush_stall,
    input  logic [SW-1:0]       i_rst_flush_stalled_set,
    output logic                o_clr_rst_stall,
    output logic                o_clr_flush_stall,
    output logic                o_incr_rst_flush_stalled_set,
    output logic                o_clr_rst_flush_stalled_set,
    output logic                o_rst_wr_en,
    output logic                o_rd_set_req,
    input  logic                i_rd_set_ack,
    input  logic [LLC_WAYS-1:0] i_lines_valid,
    input  logic [LLC_WAYS-1:0] i_lines_dirty,
    output logic                o_wb_valid,
    input  logic                i_wb_ready,
    output logic [WW-1:0]       o_wb_way,
    output logic                o_inval_en,
    output logic                o_flush_done,
    output logic                o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_WR,
        S_FL_RD,
        S_FL_WAIT,
        S_FL_SCAN,
        S_FL_NEXT
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WW-1:0]       r_way;
    logic [WW-1:0]       w_way_nxt;
    logic [LLC_WAYS-1:0] r_valid;
    logic [LLC_WAYS-1:0] r_dirty;

    logic w_latch;
    logic w_adv;
    logic w_last_set;
    logic w_last_way;
    logic w_cur_v;
    logic w_cur_d;
    logic w_in_flush;
    logic w_abort;
    logic w_wb_valid;
    logic w_clr_rst;
    logic w_clr_fl;
    logic w_incr;
    logic w_clr_set;
    logic w_rst_wr;
    logic w_rd_req;
    logic w_inval;
    logic w_done;

    assign w_last_set = (i_rst_flush_stalled_set == SW'(LLC_SETS - 1));
    assign w_last_way = (r_way == WW'(LLC_WAYS - 1));
    assign w_cur_v    = r_valid[r_way];
    assign w_cur_d    = r_dirty[r_way];
    assign w_wb_valid = (r_state == S_FL_SCAN) && w_cur_v && w_cur_d;
    assign w_in_flush = r_state inside {S_FL_RD, S_FL_WAIT, S_FL_SCAN, S_FL_NEXT};

    // A write-back in flight must finish its handshake before reset takes over
    assign w_abort = w_in_flush && i_rst_stall && (!w_wb_valid || i_wb_ready);

    always_comb begin
        w_state_nxt = r_state;
        w_way_nxt   = r_way;
        w_latch     = 1'b0;
        w_adv       = 1'b0;
        w_clr_rst   = 1'b0;
        w_clr_fl    = 1'b0;
        w_incr      = 1'b0;
        w_clr_set   = 1'b0;
        w_rst_wr    = 1'b0;
        w_rd_req    = 1'b0;
        w_inval     = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_rst_stall) begin
                    w_state_nxt = S_RST_WR;
                end else if (i_flush_stall) begin
                    w_state_nxt = S_FL_RD;
                end
            end
            S_RST_WR: begin
                w_rst_wr = 1'b1;
                if (w_last_set) begin
                    w_clr_rst   = 1'b1;
                    w_clr_set   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_incr = 1'b1;
                end
            end
            S_FL_RD: begin
                w_rd_req    = 1'b1;
                w_state_nxt = S_FL_WAIT;
            end
            S_FL_WAIT: begin
                if (i_rd_set_ack) begin
                    w_latch     = 1'b1;
                    w_way_nxt   = '0;
                    w_state_nxt = S_FL_SCAN;
                end
            end
            S_FL_SCAN: begin
                if (w_cur_v && w_cur_d) begin
                    w_inval = i_wb_ready;
                    w_adv   = i_wb_ready;
                end else begin
                    w_inval = w_cur_v;
                    w_adv   = 1'b1;
                end
            end
            S_FL_NEXT: begin
                if (w_last_set) begin
                    w_clr_fl    = 1'b1;
                    w_clr_set   = 1'b1;
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_incr      = 1'b1;
                    w_state_nxt = S_FL_RD;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_adv) begin
            if (w_last_way) begin
                w_state_nxt = S_FL_NEXT;
            end else begin
                w_way_nxt = r_way + 1'b1;
            end
        end

        // flush_stall stays set; whoever owns the reset clears it
        if (w_abort) begin
            w_state_nxt = S_RST_WR;
            w_clr_set   = 1'b1;
            w_incr      = 1'b0;
            w_clr_fl    = 1'b0;
            w_done      = 1'b0;
            w_rd_req    = 1'b0;
            w_latch     = 1'b0;
            w_inval     = w_inval && w_wb_valid;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_way   <= '0;
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_way   <= w_way_nxt;
            if (w_latch) begin
                r_valid <= i_lines_valid;
                r_dirty <= i_lines_dirty;
            end
        end
    end

    assign o_clr_rst_stall              = w_clr_rst & ~i_rst;
    assign o_clr_flush_stall            = w_clr_fl & ~i_rst;
    assign o_incr_rst_flush_stalled_set = w_incr & ~i_rst;
    assign o_clr_rst_flush_stalled_set  = w_clr_set & ~i_rst;
    assign o_rst_wr_en                  = w_rst_wr & ~i_rst;
    assign o_rd_set_req                 = w_rd_req & ~i_rst;
    assign o_wb_valid                   = w_wb_valid & ~i_rst;
    assign o_inval_en                   = w_inval & ~i_rst;
    assign o_flush_done                 = w_done & ~i_rst;
    assign o_wb_way                     = r_way;
    assign o_busy                       = (r_state != S_IDLE);

endmodule

// File: tb/tb_llc_rst_flush_seq.sv
// tb_llc_rst_flush_seq: directed and randomized walks of llc_rst_flush_seq
// against a set/way-level scoreboard with an attached register model.
module tb_llc_rst_flush_seq;

    localparam int SETS = 4;
    localparam int WAYS = 2;
    localparam int SW   = 2;
    localparam int WW   = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            rst_stall;
    logic            flush_stall;
    logic [SW-1:0]   ptr;
    logic            rd_set_ack;
    logic            wb_ready;
    logic [WAYS-1:0] lines_valid;
    logic [WAYS-1:0] lines_dirty;
    logic            clr_rst_stall;
    logic            clr_flush_stall;
    logic            incr_ptr;
    logic            clr_ptr;
    logic            rst_wr_en;
    logic            rd_set_req;
    logic            wb_valid;
    logic [WW-1:0]   wb_way;
    logic            inval_en;
    logic            flush_done;
    logic            busy;

    llc_rst_flush_seq #(
        .LLC_SETS(SETS),
        .LLC_WAYS(WAYS)
    ) dut (
        .i_clk                        (clk),
        .i_rst                        (rst),
        .i_rst_stall                  (rst_stall),
        .i_flush_stall                (flush_stall),
        .i_rst_flush_stalled_set      (ptr),
        .o_clr_rst_stall              (clr_rst_stall),
        .o_clr_flush_stall            (clr_flush_stall),
        .o_incr_rst_flush_stalled_set (incr_ptr),
        .o_clr_rst_flush_stalled_set  (clr_ptr),
        .o_rst_wr_en                  (rst_wr_en),
        .o_rd_set_req                 (rd_set_req),
        .i_rd_set_ack                 (rd_set_ack),
        .i_lines_valid                (lines_valid),
        .i_lines_dirty                (lines_dirty),
        .o_wb_valid                   (wb_valid),
        .i_wb_ready                   (wb_ready),
        .o_wb_way                     (wb_way),
        .o_inval_en                   (inval_en),
        .o_flush_done                 (flush_done),
        .o_busy                       (busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [WAYS-1:0] mv [SETS];
    logic [WAYS-1:0] md [SETS];
    int ack_dly;
    int rdy_dly;
    bit own_fl;

    bit pend;
    int ack_cnt;
    int wb_cnt;
    bit p_wbv;
    bit p_rdy;
    logic [WW-1:0] p_way;

    logic [8:0]    s_strb;
    logic          s_busy;
    logic          s_clrr, s_clrf, s_incr, s_clrp, s_rstwr;
    logic          s_req, s_wbv, s_inv, s_done;
    logic [WW-1:0] s_way;
    logic [SW-1:0] s_ptr;

    int cyc;
    int n_busy, n_incr, n_clrp, n_clrf, n_done, n_wbcyc;
    int q_rp[$], q_rwc[$], q_req[$], q_wb[$], hs_c[$];
    int q_inv[$], q_invc[$], clrr_c[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        n_busy = 0; n_incr = 0; n_clrp = 0; n_clrf = 0;
        n_done = 0; n_wbcyc = 0;
        q_rp.delete(); q_rwc.delete(); q_req.delete(); q_wb.delete();
        hs_c.delete(); q_inv.delete(); q_invc.delete(); clrr_c.delete();
        pend = 0; ack_cnt = 0; wb_cnt = 0;
    endtask

    // One clock: drive responder inputs, sample at negedge, update registers
    task automatic tick();
        logic ack;
        ack = pend && (ack_cnt >= ack_dly);
        rd_set_ack  = ack;
        lines_valid = ack ? mv[ptr] : WAYS'($urandom);
        lines_dirty = ack ? md[ptr] : WAYS'($urandom);
        wb_ready    = (wb_cnt >= rdy_dly);
        @(negedge clk);
        s_clrr  = clr_rst_stall;
        s_clrf  = clr_flush_stall;
        s_incr  = incr_ptr;
        s_clrp  = clr_ptr;
        s_rstwr = rst_wr_en;
        s_req   = rd_set_req;
        s_wbv   = wb_valid;
        s_inv   = inval_en;
        s_done  = flush_done;
        s_way   = wb_way;
        s_busy  = busy;
        s_ptr   = ptr;
        s_strb  = {s_clrr, s_clrf, s_incr, s_clrp, s_rstwr,
                   s_req, s_wbv, s_inv, s_done};
        chk("incr_clr_excl", 32'(s_incr & s_clrp), 0);
        chk("inval_rstwr_excl", 32'(s_inv & s_rstwr), 0);
        if (p_wbv && !p_rdy && !rst)
            chk("wb_hold", {s_wbv, s_way}, {1'b1, p_way});
        if (s_wbv === 1'b1)
            chk("inval_on_handshake", 32'(s_inv), 32'(wb_ready));
        if (s_busy === 1'b1) n_busy++;
        if (s_incr === 1'b1) n_incr++;
        if (s_clrp === 1'b1) n_clrp++;
        if (s_clrf === 1'b1) n_clrf++;
        if (s_done === 1'b1) n_done++;
        if (s_clrr === 1'b1) clrr_c.push_back(cyc);
        if (s_req === 1'b1) q_req.push_back(int'(s_ptr));
        if (s_rstwr === 1'b1) begin
            q_rp.push_back(int'(s_ptr));
            q_rwc.push_back(cyc);
        end
        if (s_wbv === 1'b1) begin
            n_wbcyc++;
            if (wb_ready) begin
                q_wb.push_back(int'(s_ptr) * WAYS + int'(s_way));
                hs_c.push_back(cyc);
            end
        end
        if (s_inv === 1'b1) begin
            q_inv.push_back(int'(s_ptr) * WAYS + int'(s_way));
            q_invc.push_back(cyc);
        end
        if (s_req === 1'b1) begin
            pend = 1; ack_cnt = 1;
        end else if (pend) begin
            if (ack) pend = 0;
            else ack_cnt++;
        end
        wb_cnt = (s_wbv === 1'b1 && !wb_ready) ? wb_cnt + 1 : 0;
        p_wbv = (s_wbv === 1'b1);
        p_rdy = wb_ready;
        p_way = s_way;
        cyc++;
        @(posedge clk);
        #1;
        if (s_clrr === 1'b1) begin
            rst_stall = 1'b0;
            if (own_fl) flush_stall = 1'b0;
        end
        if (s_clrf === 1'b1) flush_stall = 1'b0;
        if (s_clrp === 1'b1) ptr = '0;
        else if (s_incr === 1'b1) ptr = ptr + 1'b1;
    endtask

    task automatic run_idle(input int maxc, input string tag);
        bit seen;
        int n;
        seen = 0;
        n = 0;
        while (n < maxc && !(seen && s_busy === 1'b0)) begin
            tick();
            n++;
            if (s_busy === 1'b1) seen = 1;
        end
        chk({tag, "_finish"}, 32'(seen && s_busy === 1'b0), 1);
    endtask

    task automatic chk_q(input string tag, input int got[$], input int exp[$]);
        chk({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            chk(tag, (i < got.size()) ? got[i] : -1, exp[i]);
    endtask

    // Expected traffic derived set by set, way by way from the line contents
    task automatic flush_check(input string tag);
        int e_wb[$];
        int e_inv[$];
        int e_req[$];
        int e_cyc;
        int e_wbc;
        e_cyc = 0;
        e_wbc = 0;
        for (int s = 0; s < SETS; s++) begin
            e_req.push_back(s);
            e_cyc += 2 + ack_dly;
            for (int w = 0; w < WAYS; w++) begin
                if (mv[s][w] && md[s][w]) begin
                    e_wb.push_back(s * WAYS + w);
                    e_inv.push_back(s * WAYS + w);
                    e_cyc += rdy_dly + 1;
                    e_wbc += rdy_dly + 1;
                end else begin
                    if (mv[s][w]) e_inv.push_back(s * WAYS + w);
                    e_cyc += 1;
                end
            end
        end
        clear_stats();
        flush_stall = 1'b1;
        run_idle(200, tag);
        chk({tag, "_busy_cycles"}, n_busy, e_cyc);
        chk_q({tag, "_req_ptr"}, q_req, e_req);
        chk_q({tag, "_wb"}, q_wb, e_wb);
        chk_q({tag, "_inval"}, q_inv, e_inv);
        chk({tag, "_wb_cycles"}, n_wbcyc, e_wbc);
        chk({tag, "_done"}, n_done, 1);
        chk({tag, "_clr_flush"}, n_clrf, 1);
        chk({tag, "_clr_ptr"}, n_clrp, 1);
        chk({tag, "_incr"}, n_incr, SETS - 1);
        chk({tag, "_ptr_end"}, 32'(ptr), 0);
        chk({tag, "_flush_reg"}, 32'(flush_stall), 0);
    endtask

    task automatic clear_mem();
        for (int s = 0; s < SETS; s++) begin
            mv[s] = '0;
            md[s] = '0;
        end
    endtask

    initial begin
        int n;
        int e_rp[$];
        rst = 1'b1; rst_stall = 1'b0; flush_stall = 1'b0; ptr = '0;
        rd_set_ack = 1'b0; wb_ready = 1'b0;
        lines_valid = '0; lines_dirty = '0;
        own_fl = 0; ack_dly = 2; rdy_dly = 0;
        p_wbv = 0; p_rdy = 0; p_way = '0; cyc = 0;
        s_busy = 1'b0; s_rstwr = 1'b0; s_req = 1'b0; s_wbv = 1'b0;
        s_ptr = '0;
        clear_mem();
        clear_stats();
        #1;
        tick();
        tick();

        // Release reset with a reset walk pending
        rst = 1'b0;
        rst_stall = 1'b1;
        clear_stats();
        tick();
        chk("post_rst_busy", 32'(s_busy), 0);
        chk("post_rst_outs", {s_strb, s_way}, 0);
        run_idle(20, "rstwalk");
        e_rp = {0, 1, 2, 3};
        chk_q("rstwalk_ptr", q_rp, e_rp);
        chk("rstwalk_incr", n_incr, 3);
        chk("rstwalk_clr_ptr", n_clrp, 1);
        chk("rstwalk_clr_rst_n", clrr_c.size(), 1);
        chk("rstwalk_clr_rst_last",
            (clrr_c.size() > 0) ? clrr_c[0] : -1,
            (q_rwc.size() > 0) ? q_rwc[q_rwc.size() - 1] : -2);
        chk("rstwalk_busy", n_busy, 4);
        chk("rstwalk_stall_reg", 32'(rst_stall), 0);

        // Flush with every set invalid
        clear_mem();
        ack_dly = 2;
        rdy_dly = 0;
        flush_check("fl_inval");

        // Set 1: way0 dirty, way1 clean; slow write-back acceptance
        clear_mem();
        mv[1] = 2'b11;
        md[1] = 2'b01;
        ack_dly = 2;
        rdy_dly = 3;
        flush_check("fl_dirty");
        chk("fl_dirty_hs_inv",
            (hs_c.size() > 0) ? hs_c[0] : -1,
            (q_invc.size() > 0) ? q_invc[0] : -2);
        chk("fl_dirty_clean_next",
            (q_invc.size() > 1) ? q_invc[1] : -1,
            (q_invc.size() > 0) ? q_invc[0] + 1 : -2);

        // Randomized line contents and handshake latencies
        for (int it = 0; it < 4; it++) begin
            for (int s = 0; s < SETS; s++) begin
                mv[s] = WAYS'($urandom);
                md[s] = WAYS'($urandom);
            end
            ack_dly = $urandom_range(1, 3);
            rdy_dly = $urandom_range(0, 3);
            flush_check($sformatf("fl_rand%0d", it));
        end

        // Reset request while waiting for the read of set 2
        clear_mem();
        ack_dly = 3;
        rdy_dly = 0;
        own_fl = 1;
        clear_stats();
        flush_stall = 1'b1;
        n = 0;
        while (n < 100 && !(s_req === 1'b1 && s_ptr == 2'd2)) begin
            tick();
            n++;
        end
        chk("ab_wait_reach", 32'(s_req === 1'b1 && s_ptr == 2'd2), 1);
        rst_stall = 1'b1;
        tick();
        chk("ab_wait_clr_ptr", 32'(s_clrp), 1);
        chk("ab_wait_no_clr_fl", 32'(s_clrf), 0);
        chk("ab_wait_no_incr", 32'(s_incr), 0);
        chk("ab_wait_no_done_pre", n_done, 0);
        clear_stats();
        run_idle(20, "ab_wait_walk");
        chk_q("ab_wait_walk_ptr", q_rp, e_rp);
        chk("ab_wait_no_done", n_done, 0);
        chk("ab_wait_no_clr_fl_walk", n_clrf, 0);
        chk("ab_wait_no_req", q_req.size(), 0);

        // Reset request while a write-back waits for acceptance
        clear_mem();
        mv[0] = 2'b01;
        md[0] = 2'b01;
        ack_dly = 1;
        rdy_dly = 3;
        clear_stats();
        flush_stall = 1'b1;
        n = 0;
        while (n < 50 && s_wbv !== 1'b1) begin
            tick();
            n++;
        end
        chk("ab_wb_reach", 32'(s_wbv === 1'b1), 1);
        rst_stall = 1'b1;
        n = 0;
        while (n < 20 && hs_c.size() == 0) begin
            tick();
            n++;
        end
        chk("ab_wb_hs", hs_c.size(), 1);
        chk("ab_wb_hs_clr_ptr", 32'(s_clrp), 1);
        chk("ab_wb_hs_inval", 32'(s_inv), 1);
        chk("ab_wb_rst_wr_pre", q_rwc.size(), 0);
        run_idle(20, "ab_wb_walk");
        chk("ab_wb_walk_start",
            (q_rwc.size() > 0) ? q_rwc[0] : -1,
            (hs_c.size() > 0) ? hs_c[0] + 1 : -2);
        chk_q("ab_wb_walk_ptr", q_rp, e_rp);
        chk("ab_wb_wb_cycles", n_wbcyc, 4);
        chk("ab_wb_no_done", n_done, 0);
        own_fl = 0;

        // Synchronous reset in the middle of a reset walk
        clear_mem();
        clear_stats();
        rst_stall = 1'b1;
        n = 0;
        while (n < 20 && !(s_rstwr === 1'b1 && s_ptr == 2'd1)) begin
            tick();
            n++;
        end
        chk("rst_mid_reach", 32'(s_rstwr === 1'b1 && s_ptr == 2'd1), 1);
        rst = 1'b1;
        tick();
        chk("rst_mid_no_strobe", 32'(s_strb), 0);
        chk("rst_mid_ptr_held", 32'(ptr), 2);
        rst = 1'b0;
        tick();
        chk("rst_mid_idle_busy", 32'(s_busy), 0);
        chk("rst_mid_idle_outs", {s_strb, s_way}, 0);
        clear_stats();
        run_idle(20, "rst_mid_rewalk");
        e_rp = {2, 3};
        chk_q("rst_mid_rewalk_ptr", q_rp, e_rp);
        chk("rst_mid_rewalk_incr", n_incr, 1);
        chk("rst_mid_rewalk_clr", n_clrp, 1);
        chk("rst_mid_rewalk_ptr_end", 32'(ptr), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/llc_rst_flush_seq.md
Name: llc_rst_flush_seq

Overview:
- Sequencer directly upstream of the LLC control register file.
- Consumes the `rst_stall`, `flush_stall` and `rst_flush_stalled_set` register values. Produces the clear/increment strobes that walk those registers.
- Drives the per-set tag clear used during reset, and the per-way write-back/invalidate traffic used during flush.
- Sits between the LLC control FSM and the tag/state arrays and write-back path.

Parameters:
- LLC_SETS, 512, number of sets; power of two, >= 2; set index width SW = log2(LLC_SETS).
- LLC_WAYS, 16, ways per set; power of two, >= 2; way index width WW = log2(LLC_WAYS).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rst_stall  in  1  reset-in-progress register value
- flush_stall  in  1  flush-in-progress register value
- rst_flush_stalled_set  in  SW  current set pointer register value
- clr_rst_stall  out  1  one-cycle strobe: clears rst_stall
- clr_flush_stall  out  1  one-cycle strobe: clears flush_stall
- incr_rst_flush_stalled_set  out  1  one-cycle strobe: set pointer + 1
- clr_rst_flush_stalled_set  out  1  one-cycle strobe: set pointer := 0
- rst_wr_en  out  1  clear all tags/states of set rst_flush_stalled_set this cycle
- rd_set_req  out  1  one-cycle request to read set rst_flush_stalled_set
- rd_set_ack  in  1  read data valid this cycle
- lines_valid  in  LLC_WAYS  valid bit per way; sampled on rd_set_ack
- lines_dirty  in  LLC_WAYS  dirty bit per way; sampled on rd_set_ack
- wb_valid  out  1  write-back request for way wb_way
- wb_ready  in  1  write-back accepted
- wb_way  out  WW  way being written back or invalidated
- inval_en  out  1  invalidate way wb_way of current set this cycle
- flush_done  out  1  one-cycle pulse at flush completion
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst=1 at a clk edge):
  - FSM goes to IDLE, way counter to 0, latched vectors to 0.
  - All outputs are 0 in the following cycle.
  - Applies mid-operation as well; no strobe is emitted in that cycle.
- State IDLE:
  - If rst_stall=1, go to RST_WR.
  - Else if flush_stall=1, go to FL_RD.
  - rst_stall has priority over flush_stall.
  - Entry into a walk does not clear the pointer. The walk starts from the register's current value, which is 0 by construction.
- State RST_WR, one set per cycle:
  - Each cycle: rst_wr_en=1.
  - If rst_flush_stalled_set == LLC_SETS-1: assert clr_rst_stall and clr_rst_flush_stalled_set, do not assert incr, go to IDLE.
  - Otherwise assert incr_rst_flush_stalled_set and stay.
  - The full reset walk takes exactly LLC_SETS cycles with rst_wr_en high.
- State FL_RD:
  - rd_set_req=1 for exactly the entry cycle, then go to FL_WAIT.
- State FL_WAIT:
  - Hold until rd_set_ack=1.
  - On ack: latch lines_valid/lines_dirty, set way counter to 0, go to FL_SCAN.
- State FL_SCAN (w = way counter; wb_way = w):
  - valid[w] & dirty[w]: wb_valid=1 and held until wb_ready. On the handshake cycle inval_en=1 and advance. wb_valid never drops without a handshake.
  - valid[w] & !dirty[w]: inval_en=1 for one cycle, advance.
  - !valid[w]: one idle cycle, advance.
  - Advance: if w == LLC_WAYS-1, go to FL_NEXT; else w+1.
- State FL_NEXT:
  - If pointer == LLC_SETS-1: assert clr_flush_stall, clr_rst_flush_stalled_set and flush_done, go to IDLE.
  - Else assert incr_rst_flush_stalled_set, go to FL_RD.
- Abort:
  - If rst_stall=1 in any FL_* state and no write-back is outstanding (wb_valid=0), go to RST_WR next cycle.
  - In the same cycle assert clr_rst_flush_stalled_set, but not clr_flush_stall.
  - flush_stall is cleared by the owner of the reset state.
  - If wb_valid=1, the abort waits for the handshake.
- Strobes:
  - incr and clr of the set pointer are never asserted in the same cycle.
  - inval_en and rst_wr_en are mutually exclusive.
- Counters: way counter is WW bits wide and never wraps past LLC_WAYS-1.
- busy: 1 in every state except IDLE.

Test Plan:
- LLC_SETS=4, LLC_WAYS=2; release rst with rst_stall=1, register model attached.
  - rst_wr_en high for 4 cycles with pointer 0,1,2,3.
  - incr on the first 3 cycles; clr_rst_stall and clr pointer on the 4th.
  - busy=0 on the next cycle.
- Flush, all sets invalid, rd_set_ack 2 cycles after each req.
  - 4 rd_set_req pulses; zero wb_valid and zero inval_en.
  - flush_done once; clr_flush_stall once; total 4*(1+2+2+1)=24 cycles.
- Flush, set 1 = {way0 valid dirty, way1 valid clean}, wb_ready delayed 3 cycles.
  - wb_valid held with wb_way=0 until ready; inval_en on the handshake cycle.
  - inval_en with wb_way=1 the next cycle.
  - No other wb_valid during the flush.
- Mid-flush rst_stall=1 while in FL_WAIT on set 2.
  - clr_rst_flush_stalled_set next cycle, then a 4-cycle RST_WR walk.
  - No flush_done.
- Abort during a pending write-back.
  - wb_valid stays 1 until wb_ready; RST_WR starts the cycle after the handshake.
- rst asserted during RST_WR at pointer 2.
  - All outputs 0 next cycle; FSM in IDLE.
  - Re-entry on rst_stall=1 restarts from the register's pointer value.
